mem_dump: RTL

MEM_DUMP -- requirements
Module: mem_dump

---
 rtl/mem_dump.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_dump.sv
// Walks a synchronous data memory from base_addr for word_count words and streams
// {addr, data} over a valid/ready port. Define MEM_DUMP_CHECKSUM_EN to build the running checksum.
module mem_dump #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT, S_DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] addr_next;

  assign xfer      = (state_q == S_OUT) && out_ready;
  assign addr_next = addr_q + ADDR_STEP;

  // Outputs are computed for the state being entered so they are registered yet
  // line up with it: mem_rd_en is high exactly while the FSM sits in ISSUE.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = word_count;
          if (word_count == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = S_ISSUE;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = base_addr;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        out_data_d  = mem_rdata;
        out_addr_d  = addr_q;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          addr_d      = addr_next;
          remaining_d = remaining_q - CNT_WIDTH'(1);
          if (remaining_q > CNT_WIDTH'(1)) begin
            state_d     = S_ISSUE;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = addr_next;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == S_IDLE && start) checksum_d = '0;
    else if (xfer)                  checksum_d = checksum_q + out_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) checksum_q <= '0;
    else        checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule
